dsep_stream: RTL
================

// Module: dsep_stream
// PURPOSE
//  Streaming data separator between CFOC/SSYNC and the FFT stage. Buffers compensated
//  samples, waits for the symbol-sync index, then splits the frame into a preamble
//  stream and a signal&payload stream, optionally stripping the CP.
//  Reading starts as soon as sync is known (no full-buffer wait), so the block supports
//  back-to-back frames, a sync timeout, and sticky overflow/flag reporting.
// PARAMETERS
//  DW        12    sample width per I/Q component (signed)
//  AW        13    buffer address width; DEPTH = 2**AW
//  IDX_W     10    width of max_indx
//  N         512   FFT symbol length
//  CP_LEN    32    cyclic prefix length
//  PRB_NUM   8     preamble symbols after sync point; output = symbols 2..PRB_NUM-1
//  MAX_SYM   6     signal + payload symbols per frame
//  CP_STRIP  0     1: suppress the first CP_LEN samples of each sigpld symbol
// PORTS
//  clk             in   1      working clock
//  rst             in   1      reset, asynchronous, active-high
//  di_re/di_im     in   DW     compensated input sample (signed)
//  di_vld          in   1      input sample valid
//  max_indx        in   IDX_W  symbol sync index (SSYNC reports +1)
//  max_indx_vld    in   1      sync index valid (1-cycle pulse)
//  do_pre_re/im    out  DW     preamble sample
//  do_pre_vld      out  1      preamble sample valid
//  do_sp_re/im     out  DW     signal&payload sample
//  do_sp_vld       out  1      signal&payload sample valid
//  do_sp_sos       out  1      start-of-symbol marker (first emitted sample of each symbol)
//  frame_done      out  1      1-cycle pulse after the last sigpld sample
//  sync_timeout    out  1      1-cycle pulse: buffer filled without sync, frame dropped
//  overflow        out  1      sticky: required frame length > DEPTH; cleared only by rst
//  busy            out  1      FSM not in IDLE
// BEHAVIOUR
//  - Reset: all outputs 0, FSM=IDLE, all pointers 0. rst mid-frame aborts immediately;
//    buffer contents are discarded.
//  - off = max_indx-1 (IDX_W bits, registered on accepted pulse).
//  - LEN = off + N*(PRB_NUM-1) + (N+CP_LEN)*MAX_SYM.
//  - FSM states:
//    IDLE: first di_vld writes addr 0 -> FILL. max_indx_vld ignored.
//    FILL: each di_vld writes at wr_ptr++. max_indx_vld latches off.
//      LEN > DEPTH -> set overflow, go IDLE.
//      Otherwise -> DRAIN.
//      wr_ptr reaches DEPTH with no sync -> pulse sync_timeout, go IDLE.
//    DRAIN: writes continue until wr_ptr==LEN; later di_vld are dropped.
//      A read is issued each cycle while rd_ptr<wr_ptr.
//      After rd_ptr==LEN and the pipeline is empty -> pulse frame_done, go IDLE.
//      Further max_indx_vld ignored.
//  - Read classification by rd_ptr:
//    [0, off+N)                 discarded
//    [off+N, off+N*(PRB_NUM-1)) preamble, do_pre_vld=1
//    [off+N*(PRB_NUM-1), LEN)   sigpld; pos within symbol = (rd_ptr-base) mod (N+CP_LEN)
//  - CP_STRIP=1: pos<CP_LEN not emitted; sos at pos==CP_LEN. CP_STRIP=0: sos at pos==0.
//  - Latency: read issue -> RAM (1 clk) -> output reg (1 clk) = 2 clk.
//    Non-valid cycles drive data 0.
//  - Simultaneous di_vld and max_indx_vld in FILL: the sample is written and off latched.
//    Reading starts the next cycle.
//  - Same-cycle write/read of one address cannot occur: rd_ptr<wr_ptr is strict.
//  - Input gaps stall reading without losing order. Read rate >= write rate, so no
//    backpressure is needed.
// STRUCTURE
//  - Shared package dsep_pkg: FSM state enum (IDLE/FILL/DRAIN), region enum
//    (SKIP/PRE/SP), and LEN/base computation functions.
//  - One sub-module: dsep_sdp_ram (simple dual-port, 2*DW x DEPTH, 1-clk registered
//    read, no reset).
// TESTING (defaults; max_indx=115 -> off=114, LEN=6962)
//  1. Continuous di_vld ramp, sync at input #300:
//     - 3072 do_pre_vld, first value = input #626;
//     - 3264 do_sp_vld starting at input #3698;
//     - 6 sos spaced 544 apart;
//     - frame_done once.
//  2. CP_STRIP=1, same stimulus: 3072 sigpld samples; first is input #3730; sos every
//     512 samples.
//  3. No max_indx_vld for 8192 samples: sync_timeout pulses at wr_ptr=8192; no outputs;
//     next frame processes normally.
//  4. max_indx=1023 with AW=12 (LEN>4096): overflow set and held, no outputs, busy drops.
//  5. di_vld 50% random gaps plus a second sync pulse mid-DRAIN: output sequence and
//     counts identical to test 1.
//  6. rst asserted mid-DRAIN, then two back-to-back frames: outputs 0 during reset;
//     both frames correct; frame_done pulses twice.

Source files
------------

// File: rtl/dsep_pkg.sv
// Shared types and frame-geometry helpers for the data separator.
package dsep_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_DRAIN} state_t;
  typedef enum logic [1:0] {RG_SKIP, RG_PRE, RG_SP} region_t;

  function automatic int calc_pre_start(input int off, input int n);
    return off + n;
  endfunction

  function automatic int calc_sp_base(input int off, input int n, input int prb_num);
    return off + n * (prb_num - 1);
  endfunction

  function automatic int calc_len(input int off, input int n, input int cp_len,
                                  input int prb_num, input int max_sym);
    return calc_sp_base(off, n, prb_num) + (n + cp_len) * max_sym;
  endfunction

endpackage

// File: rtl/dsep_sdp_ram.sv
// Simple dual-port sample buffer: one write port, one read port with a registered output.
module dsep_sdp_ram #(
  parameter int DATA_W = 24,
  parameter int AW     = 13
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [AW-1:0]     i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [2**AW];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/dsep_stream.sv
// Buffers compensated samples, waits for the symbol-sync index, then splits the frame
// into a preamble stream and a signal&payload stream (optionally stripping the CP).
module dsep_stream
  import dsep_pkg::*;
#(
  parameter int DW       = 12,
  parameter int AW       = 13,
  parameter int IDX_W    = 10,
  parameter int N        = 512,
  parameter int CP_LEN   = 32,
  parameter int PRB_NUM  = 8,
  parameter int MAX_SYM  = 6,
  parameter int CP_STRIP = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic signed [DW-1:0] di_re,
  input  logic signed [DW-1:0] di_im,
  input  logic                 di_vld,
  input  logic [IDX_W-1:0]     max_indx,
  input  logic                 max_indx_vld,
  output logic signed [DW-1:0] do_pre_re,
  output logic signed [DW-1:0] do_pre_im,
  output logic                 do_pre_vld,
  output logic signed [DW-1:0] do_sp_re,
  output logic signed [DW-1:0] do_sp_im,
  output logic                 do_sp_vld,
  output logic                 do_sp_sos,
  output logic                 frame_done,
  output logic                 sync_timeout,
  output logic                 overflow,
  output logic                 busy
);

  localparam int PTR_W = AW + 1;
  localparam int DEPTH = 2**AW;
  localparam int PW    = $clog2(N + CP_LEN);
  localparam logic [PTR_W-1:0] DEPTH_P  = PTR_W'(DEPTH);
  localparam logic [PW-1:0]    POS_LAST = PW'(N + CP_LEN - 1);
  localparam logic [PW-1:0]    CP_POS   = PW'(CP_LEN);
  localparam logic [PW-1:0]    SOS_POS  = PW'((CP_STRIP != 0) ? CP_LEN : 0);

  state_t           r_state;
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr, r_len, r_pre_start, r_sp_base;
  logic [PW-1:0]    r_pos;
  logic             r_vld_rd_p1, r_vld_pre_p1, r_vld_sp_p1, r_sos_p1;

  logic [IDX_W-1:0]     w_off;
  int                   w_len, w_pre_start, w_sp_base;
  logic                 w_wr_en, w_rd_en, w_emit_sp;
  logic [AW-1:0]        w_wr_addr;
  region_t              w_region;
  logic [2*DW-1:0]      w_rd_data;
  logic signed [DW-1:0] w_rd_re, w_rd_im;

  // SSYNC reports the index one past the true sync point.
  assign w_off       = max_indx - IDX_W'(1);
  assign w_pre_start = calc_pre_start(int'(w_off), N);
  assign w_sp_base   = calc_sp_base(int'(w_off), N, PRB_NUM);
  assign w_len       = calc_len(int'(w_off), N, CP_LEN, PRB_NUM, MAX_SYM);

  assign w_wr_en = di_vld && ((r_state == ST_IDLE) ||
                              (r_state == ST_FILL  && r_wr_ptr < DEPTH_P) ||
                              (r_state == ST_DRAIN && r_wr_ptr < r_len));
  assign w_wr_addr = (r_state == ST_IDLE) ? '0 : r_wr_ptr[AW-1:0];
  assign w_rd_en   = (r_state == ST_DRAIN) && (r_rd_ptr < r_wr_ptr);

  assign w_region  = (r_rd_ptr < r_pre_start) ? RG_SKIP :
                     (r_rd_ptr < r_sp_base)   ? RG_PRE  : RG_SP;
  assign w_emit_sp = (CP_STRIP == 0) || (r_pos >= CP_POS);
  assign busy      = (r_state != ST_IDLE);

  dsep_sdp_ram #(.DATA_W(2*DW), .AW(AW)) u_ram (
    .clk     (clk),
    .i_we    (w_wr_en),
    .i_waddr (w_wr_addr),
    .i_wdata ({di_re, di_im}),
    .i_re    (w_rd_en),
    .i_raddr (r_rd_ptr[AW-1:0]),
    .o_rdata (w_rd_data)
  );

  assign w_rd_re = w_rd_data[2*DW-1:DW];
  assign w_rd_im = w_rd_data[DW-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_len        <= '0;
      r_pre_start  <= '0;
      r_sp_base    <= '0;
      r_pos        <= '0;
      frame_done   <= 1'b0;
      sync_timeout <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      frame_done   <= 1'b0;
      sync_timeout <= 1'b0;
      if (w_wr_en) r_wr_ptr <= (r_state == ST_IDLE) ? PTR_W'(1) : r_wr_ptr + PTR_W'(1);
      case (r_state)
        ST_IDLE: begin
          if (di_vld) begin
            r_state  <= ST_FILL;
            r_rd_ptr <= '0;
            r_pos    <= '0;
          end
        end
        ST_FILL: begin
          if (max_indx_vld) begin
            if (w_len > DEPTH) begin
              overflow <= 1'b1;
              r_state  <= ST_IDLE;
            end else begin
              r_len       <= PTR_W'(w_len);
              r_pre_start <= PTR_W'(w_pre_start);
              r_sp_base   <= PTR_W'(w_sp_base);
              r_state     <= ST_DRAIN;
            end
          end else if (r_wr_ptr == DEPTH_P) begin
            sync_timeout <= 1'b1;
            r_state      <= ST_IDLE;
          end
        end
        ST_DRAIN: begin
          if (w_rd_en) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            if (w_region == RG_SP) r_pos <= (r_pos == POS_LAST) ? '0 : r_pos + PW'(1);
          end
          if (r_rd_ptr == r_len && !r_vld_rd_p1) begin
            frame_done <= 1'b1;
            r_state    <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_rd_p1  <= 1'b0;
      r_vld_pre_p1 <= 1'b0;
      r_vld_sp_p1  <= 1'b0;
      r_sos_p1     <= 1'b0;
      do_pre_vld   <= 1'b0;
      do_pre_re    <= '0;
      do_pre_im    <= '0;
      do_sp_vld    <= 1'b0;
      do_sp_sos    <= 1'b0;
      do_sp_re     <= '0;
      do_sp_im     <= '0;
    end else begin
      // p1: classification travels alongside the RAM read
      r_vld_rd_p1  <= w_rd_en;
      r_vld_pre_p1 <= w_rd_en && (w_region == RG_PRE);
      r_vld_sp_p1  <= w_rd_en && (w_region == RG_SP) && w_emit_sp;
      r_sos_p1     <= w_rd_en && (w_region == RG_SP) && (r_pos == SOS_POS);
      // p2: output registers, zero on non-valid cycles
      do_pre_vld   <= r_vld_pre_p1;
      do_pre_re    <= r_vld_pre_p1 ? w_rd_re : '0;
      do_pre_im    <= r_vld_pre_p1 ? w_rd_im : '0;
      do_sp_vld    <= r_vld_sp_p1;
      do_sp_sos    <= r_sos_p1;
      do_sp_re     <= r_vld_sp_p1 ? w_rd_re : '0;
      do_sp_im     <= r_vld_sp_p1 ? w_rd_im : '0;
    end
  end

endmodule
